// File: rtl/mux2_rr_arbiter_if.sv
// Requester, mux-control and consumer-side signals of the 2:1 round-robin arbiter.
// Handshake: a word moves to the consumer on a rising edge where out_valid=1 and
// out_ready=1; a requester word is captured on the edge where its gnt is high.
interface mux2_rr_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             gnt0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt1;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             sel;
    logic             en;
    logic [CNT_W-1:0] xfer_count;
    logic             state_dbg;

    modport slave (
        input  req0, data0, req1, data1, out_ready,
        output gnt0, gnt1, out_data, out_valid, sel, en, xfer_count, state_dbg
    );

    modport master (
        output req0, data0, req1, data1, out_ready,
        input  gnt0, gnt1, out_data, out_valid, sel, en, xfer_count, state_dbg
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter in front of a shared 2:1 mux with a one-entry output buffer.
// A new word is accepted when the buffer is empty or drained in the same cycle.
module mux2_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mux2_rr_arbiter_if.slave       bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             sel_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic drain;
    logic accept;
    logic winner;
    logic gnt0;
    logic gnt1;
    logic grant;

    assign drain  = (state_q == FULL) & bus.out_ready;
    assign accept = (state_q == EMPTY) | bus.out_ready;

    // On a tie the requester that did not win last time takes the slot.
    assign winner = (bus.req0 & bus.req1) ? ~last_grant_q : bus.req1;

    assign gnt0  = reset_n & accept & bus.req0 & ~winner;
    assign gnt1  = reset_n & accept & bus.req1 & winner;
    assign grant = gnt0 | gnt1;

    assign data_d = winner ? bus.data1 : bus.data0;
    assign cnt_d  = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            data_q       <= '0;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                EMPTY: if (grant) state_q <= FULL;
                FULL:  if (drain && !grant) state_q <= EMPTY;
            endcase
            if (grant) begin
                data_q       <= data_d;
                sel_q        <= winner;
                last_grant_q <= winner;
            end
            if (drain) begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.out_data   = data_q;
    assign bus.out_valid  = (state_q == FULL);
    assign bus.en         = (state_q == FULL);
    assign bus.sel        = sel_q;
    assign bus.xfer_count = cnt_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Randomized and directed bench for mux2_rr_arbiter with a queue-based scoreboard.
module tb_mux2_rr_arbiter;
    localparam int W  = 4;
    localparam int CW = 8;

    logic clk;
    logic reset_n;

    mux2_rr_arbiter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    mux2_rr_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state: {sel, data} of each word expected at the consumer
    logic [W:0]    exp_q[$];
    logic          m_last;
    logic [CW-1:0] m_cnt;
    logic          m_sel;
    logic [W-1:0]  m_data;
    int            tests;
    int            fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every output handshake pops one expected word
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL drain_unexpected: got word %0h expected none at %0t", bus.out_data, $time);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("drain_data", 32'(bus.out_data), 32'(e[W-1:0]));
                check("drain_sel", 32'(bus.sel), 32'(e[W]));
            end
        end
    end

    // driver: one cycle of stimulus, with grant / state checks from the model
    task automatic cycle(input logic r0, input logic [W-1:0] d0, input logic r1,
                         input logic [W-1:0] d1, input logic rdy, input logic rst_n,
                         output logic g0, output logic g1);
        logic empty, acc, win;
        bus.req0      = r0;
        bus.data0     = d0;
        bus.req1      = r1;
        bus.data1     = d1;
        bus.out_ready = rdy;
        reset_n       = rst_n;
        #1;
        empty = (exp_q.size() == 0);
        acc   = empty || rdy;
        win   = (r0 && r1) ? !m_last : r1;
        g0    = rst_n && acc && r0 && !win;
        g1    = rst_n && acc && r1 && win;
        check("gnt0", 32'(bus.gnt0), 32'(g0));
        check("gnt1", 32'(bus.gnt1), 32'(g1));
        check("out_valid", 32'(bus.out_valid), 32'(!empty));
        check("en", 32'(bus.en), 32'(!empty));
        check("sel", 32'(bus.sel), 32'(m_sel));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("xfer_count", 32'(bus.xfer_count), 32'(m_cnt));
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_last = 1'b1;
            m_cnt  = '0;
            m_sel  = 1'b0;
            m_data = '0;
        end else begin
            if (!empty && rdy) m_cnt = m_cnt + 1'b1;
            if (g0 || g1) begin
                m_last = win;
                m_sel  = win;
                m_data = win ? d1 : d0;
                exp_q.push_back({win, m_data});
            end
        end
        #1;
    endtask

    task automatic do_reset();
        logic g0, g1;
        cycle(1'b1, 4'h2, 1'b1, 4'h5, 1'b1, 1'b0, g0, g1);
        check("rst_gnt0", 32'(bus.gnt0), 32'(0));
        check("rst_valid", 32'(bus.out_valid), 32'(0));
    endtask

    initial begin
        logic g0, g1;
        logic r0, r1;
        logic [W-1:0] d0, d1;
        tests = 0;
        fails = 0;
        m_last = 1'b1;
        m_cnt = '0;
        m_sel = 1'b0;
        m_data = '0;
        bus.req0 = 1'b0;
        bus.data0 = '0;
        bus.req1 = 1'b0;
        bus.data1 = '0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset with req0 pending, then first grant
        cycle(1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, g0, g1);
        cycle(1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, g0, g1);
        cycle(1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 1'b1, g0, g1);
        check("t1_gnt0", 32'(g0), 32'(1));
        check("t1_data", 32'(bus.out_data), 32'(4'h2));
        check("t1_sel", 32'(bus.sel), 32'(0));
        check("t1_valid", 32'(bus.out_valid), 32'(1));
        check("t1_cnt", 32'(bus.xfer_count), 32'(0));

        // 2: tie with full throughput alternates 0,1,0,1
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'h2, 1'b1, 4'h5, 1'b1, 1'b1, g0, g1);
            if (i < 4) check("t2_alt", 32'(g1), 32'(i % 2));
        end
        check("t2_cnt", 32'(bus.xfer_count), 32'(4));

        // 3: backpressure holds the buffer and blocks grants
        do_reset();
        cycle(1'b1, 4'h2, 1'b1, 4'h5, 1'b0, 1'b1, g0, g1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'h2, 1'b1, 4'h5, 1'b0, 1'b1, g0, g1);
        check("t3_hold", 32'(bus.out_data), 32'(4'h2));
        cycle(1'b0, 4'h2, 1'b1, 4'h5, 1'b1, 1'b1, g0, g1);
        check("t3_gnt1", 32'(g1), 32'(1));
        check("t3_data", 32'(bus.out_data), 32'(4'h5));

        // 4: single req1, idle keeps sel, later req0 granted immediately
        do_reset();
        cycle(1'b0, 4'h0, 1'b1, 4'hA, 1'b1, 1'b1, g0, g1);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, g0, g1);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, g0, g1);
        check("t4_sel_kept", 32'(bus.sel), 32'(1));
        check("t4_empty", 32'(bus.out_valid), 32'(0));
        cycle(1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b1, g0, g1);
        check("t4_gnt0", 32'(g0), 32'(1));

        // 5: reset while full and stalled, then tie goes to requester 0
        cycle(1'b0, 4'h0, 1'b1, 4'h5, 1'b1, 1'b1, g0, g1);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, g0, g1);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, g0, g1);
        check("t5_valid", 32'(bus.out_valid), 32'(0));
        check("t5_sel", 32'(bus.sel), 32'(0));
        check("t5_cnt", 32'(bus.xfer_count), 32'(0));
        cycle(1'b1, 4'h7, 1'b1, 4'h9, 1'b0, 1'b1, g0, g1);
        check("t5_tie", 32'(g0), 32'(1));

        // 6: counter wraps after 256 drains
        do_reset();
        for (int i = 0; i < 256; i++) cycle(1'b1, 4'(i), 1'b0, 4'h0, 1'b1, 1'b1, g0, g1);
        check("t6_ff", 32'(bus.xfer_count), 32'(8'hFF));
        cycle(1'b1, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, g0, g1);
        check("t6_wrap", 32'(bus.xfer_count), 32'(8'h00));

        // random traffic with held requests, withdrawals and occasional resets
        r0 = 1'b0;
        r1 = 1'b0;
        d0 = '0;
        d1 = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!r0) begin r0 = ($urandom_range(0, 2) != 0); d0 = 4'($urandom); end
            else if ($urandom_range(0, 15) == 0) r0 = 1'b0;
            if (!r1) begin r1 = ($urandom_range(0, 2) != 0); d1 = 4'($urandom); end
            else if ($urandom_range(0, 15) == 0) r1 = 1'b0;
            cycle(r0, d0, r1, d1, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 199) != 0), g0, g1);
            if (g0) r0 = 1'b0;
            if (g1) r1 = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
